// File: rtl/logic_gate_unit.sv
// Two-stage valid/ready logic unit: reduces NUM_IN operands with one of eight bitwise ops,
// registers the result with zero/ones/parity flags and counts completed output transfers.

module logic_gate_lane #(
    parameter int NUM_IN = 2
) (
    input  logic [2:0]        op,
    input  logic [NUM_IN-1:0] bits,
    output logic              y
);
    logic r_and, r_or, r_xor;

    assign r_and = &bits;
    assign r_or  = |bits;
    assign r_xor = ^bits;

    always_comb begin
        y = 1'b0;
        case (op)
            3'b000:  y = r_and;
            3'b001:  y = r_or;
            3'b010:  y = r_xor;
            3'b011:  y = ~r_and;
            3'b100:  y = ~r_or;
            3'b101:  y = ~r_xor;
            3'b110:  y = ~bits[0];
            default: y = bits[0];
        endcase
    end
endmodule

module logic_gate_unit #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_op,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_zero,
    output logic                    out_ones,
    output logic                    out_parity,
    output logic [CNT_W-1:0]        txn_count
);
    logic [2:1]                  vld_pipe;
    logic [2:0]                  s1_op;
    logic [NUM_IN*WIDTH-1:0]     s1_data;
    logic [WIDTH-1:0][NUM_IN-1:0] lane_bits;
    logic [WIDTH-1:0]            s1_res;
    logic                        s2_free, in_fire, s1_move, out_fire;

    assign s2_free  = !vld_pipe[2] || out_ready;
    assign in_ready = !vld_pipe[1] || s2_free;
    assign in_fire  = in_valid && in_ready;
    assign s1_move  = vld_pipe[1] && s2_free;
    assign out_fire = vld_pipe[2] && out_ready;
    assign out_valid = vld_pipe[2];

    // Transpose operands so each result bit gets its own lane across all operands.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        for (genvar k = 0; k < NUM_IN; k++) begin : g_op
            assign lane_bits[b][k] = s1_data[k*WIDTH + b];
        end
        logic_gate_lane #(.NUM_IN(NUM_IN)) u_lane (
            .op   (s1_op),
            .bits (lane_bits[b]),
            .y    (s1_res[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[1] <= 1'b0;
            s1_op       <= '0;
            s1_data     <= '0;
        end else if (in_fire) begin
            vld_pipe[1] <= 1'b1;
            s1_op       <= in_op;
            s1_data     <= in_data;
        end else if (s1_move) begin
            vld_pipe[1] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe[2] <= 1'b0;
            out_data    <= '0;
            out_zero    <= 1'b0;
            out_ones    <= 1'b0;
            out_parity  <= 1'b0;
        end else if (s1_move) begin
            vld_pipe[2] <= 1'b1;
            out_data    <= s1_res;
            out_zero    <= (s1_res == '0);
            out_ones    <= (&s1_res);
            out_parity  <= (^s1_res);
        end else if (out_fire) begin
            vld_pipe[2] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        txn_count <= '0;
        else if (out_fire) txn_count <= txn_count + 1'b1;
    end
endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed bench: a 2-operand/16-bit-counter unit and a 4-operand/4-bit-counter unit
// driven with hand-computed vectors.

module tb_logic_gate_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // 2-operand unit
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  in_op;
    logic [15:0] in_data;
    logic [7:0]  out_data;
    logic        out_zero, out_ones, out_parity;
    logic [15:0] txn_count;

    // 4-operand unit with 4-bit counter
    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [2:0]  in_op4;
    logic [31:0] in_data4;
    logic [7:0]  out_data4;
    logic        out_zero4, out_ones4, out_parity4;
    logic [3:0]  txn_count4;

    int checks = 0;
    int errors = 0;

    logic_gate_unit #(.WIDTH(8), .NUM_IN(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_zero(out_zero), .out_ones(out_ones),
        .out_parity(out_parity), .txn_count(txn_count)
    );

    logic_gate_unit #(.WIDTH(8), .NUM_IN(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_op(in_op4), .in_data(in_data4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out_data(out_data4), .out_zero(out_zero4), .out_ones(out_ones4),
        .out_parity(out_parity4), .txn_count(txn_count4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] t1_a   [4] = '{8'h00, 8'h00, 8'hFF, 8'hFF};
    logic [7:0] t1_b   [4] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    logic [7:0] t1_exp [4] = '{8'h00, 8'h00, 8'h00, 8'hFF};
    logic [7:0] t2_exp [8] = '{8'h81, 8'hE7, 8'h66, 8'h7E, 8'h18, 8'h99, 8'h3C, 8'hC3};

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_op = 0; in_data = 0; out_ready = 1;
        in_valid4 = 0; in_op4 = 0; in_data4 = 0; out_ready4 = 1;
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_flags", {29'b0, out_zero, out_ones, out_parity}, 0);
        chk("rst_txn", 32'(txn_count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        tick();

        // 1: AND sweep, back-to-back, first result two edges after acceptance
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                in_valid = 1; in_op = 3'b000; in_data = {t1_b[i], t1_a[i]};
            end else in_valid = 0;
            tick();
            if (i == 0) chk("t1_lat_valid", 32'(out_valid), 0);
            if (i >= 1 && i <= 4) begin
                chk($sformatf("t1_valid%0d", i-1), 32'(out_valid), 1);
                chk($sformatf("t1_data%0d", i-1), 32'(out_data), 32'(t1_exp[i-1]));
            end
        end
        chk("t1_txn", 32'(txn_count), 4);

        // 2: all ops on A=C3, B=A5
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                in_valid = 1; in_op = 3'(i); in_data = {8'hA5, 8'hC3};
            end else in_valid = 0;
            tick();
            if (i >= 1 && i <= 8)
                chk($sformatf("t2_op%0d", i-1), 32'(out_data), 32'(t2_exp[i-1]));
            if (i == 1)
                chk("t2_flags81", {29'b0, out_zero, out_ones, out_parity}, 0);
        end

        // 3: backpressure with PASS
        rst_n = 0; #1; rst_n = 1;
        out_ready = 0;
        in_valid = 1; in_op = 3'b111; in_data = 16'h0001;
        chk("t3_ready0", 32'(in_ready), 1);
        tick();
        in_data = 16'h0002;
        chk("t3_ready1", 32'(in_ready), 1);
        tick();
        in_data = 16'h0003;
        chk("t3_ready_low", 32'(in_ready), 0);
        tick();
        chk("t3_hold_data", 32'(out_data), 8'h01);
        chk("t3_hold_valid", 32'(out_valid), 1);
        chk("t3_still_low", 32'(in_ready), 0);
        chk("t3_txn_held", 32'(txn_count), 0);
        out_ready = 1;
        #1 chk("t3_ready_comb", 32'(in_ready), 1);
        tick();
        in_valid = 0;
        chk("t3_out02", 32'(out_data), 8'h02);
        tick();
        chk("t3_out03", 32'(out_data), 8'h03);
        chk("t3_out03_v", 32'(out_valid), 1);
        tick();
        chk("t3_drained", 32'(out_valid), 0);
        chk("t3_txn", 32'(txn_count), 3);

        // 4: four operands
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                in_valid4 = 1; in_op4 = 3'b010; in_data4 = {8'h01, 8'hFF, 8'hF0, 8'h0F};
            end else if (i == 1) begin
                in_valid4 = 1; in_op4 = 3'b000; in_data4 = 32'hFFFF_FFFF;
            end else in_valid4 = 0;
            tick();
            if (i == 1) begin
                chk("t4_xor", 32'(out_data4), 8'h01);
                chk("t4_xor_par", 32'(out_parity4), 1);
                chk("t4_xor_ones", 32'(out_ones4), 0);
            end
            if (i == 2) begin
                chk("t4_and", 32'(out_data4), 8'hFF);
                chk("t4_and_ones", 32'(out_ones4), 1);
                chk("t4_and_zero", 32'(out_zero4), 0);
            end
        end

        // 5: reset while two transactions are in flight
        out_ready = 0;
        in_valid = 1; in_op = 3'b111; in_data = 16'h0055;
        tick();
        in_data = 16'h00AA;
        tick();
        in_valid = 0;
        chk("t5_inflight", 32'(out_valid), 1);
        #2 rst_n = 0;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 0);
        chk("t5_rst_txn", 32'(txn_count), 0);
        chk("t5_rst_data", 32'(out_data), 0);
        #1 rst_n = 1;
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t5_no_stale%0d", i), 32'(out_valid), 0);
        end

        // 6: 4-bit counter wrap over 17 transfers
        for (int i = 0; i < 19; i++) begin
            if (i < 17) begin
                in_valid4 = 1; in_op4 = 3'b111; in_data4 = 32'(i);
            end else in_valid4 = 0;
            tick();
            if (i == 16) chk("t6_cnt15", 32'(txn_count4), 15);
            if (i == 17) chk("t6_wrap0", 32'(txn_count4), 0);
            if (i == 18) chk("t6_cnt1", 32'(txn_count4), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
